fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-port scheduler that lets NREQ independent producers share the single write port of the dual-clock FIFO.
- Sits entirely in the write clock domain, in front of the FIFO write side.
- Grants one requester at a time for a packet or bounded burst, gates every beat against wfull, and tags each beat with its source.
- The FIFO data width is sized to carry the tag alongside the data.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DSIZE, 8, data width per requester.
- MAX_BURST, 4, maximum beats per grant before forced re-arbitration (1..256).
- IDW, $clog2(NREQ), width of the source tag.

Ports:
- wclk  in  1  write-domain clock; all state on rising edge.
- wrst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_data  in  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
- req_last  in  NREQ  per-requester end-of-packet marker, qualified by req_valid.
- req_ready  out  NREQ  per-requester beat accepted (one-hot or zero).
- wfull  in  1  FIFO full flag, already in the wclk domain.
- winc  out  1  FIFO write enable.
- wdata  out  DSIZE  data to FIFO.
- wtag  out  IDW  index of the requester owning the current beat.
- busy  out  1  high while in GRANT.

Behaviour:
- Reset, synchronous, while wrst=1 at a rising edge:
  - state<=IDLE, cur<=0, rr_ptr<=0, beat_cnt<=0.
  - winc, req_ready and busy are forced 0 combinationally while wrst=1.
- FSM has two states: IDLE and GRANT.
- IDLE:
  - If any req_valid, select the first i with req_valid[i]=1, scanning cyclically from rr_ptr upward.
  - cur<=i, beat_cnt<=0, state<=GRANT.
  - No transfer occurs in IDLE, so there is one arbitration cycle per grant.
  - With no valid, stay in IDLE.
- GRANT:
  - xfer = req_valid[cur] & ~wfull.
  - winc = xfer, req_ready[cur] = xfer, all other req_ready=0.
  - wdata = req_data slice cur; wtag = cur.
  - On xfer with no release condition: beat_cnt<=beat_cnt+1.
  - Release condition: xfer & (req_last[cur] | beat_cnt==MAX_BURST-1).
  - On release: state<=IDLE, rr_ptr<=(cur==NREQ-1)?0:cur+1, beat_cnt<=0.
  - req_valid[cur]=0 mid-burst: hold the grant and insert bubbles; other requesters wait (packet lock).
  - wfull=1: no transfer, beat_cnt unchanged, grant held.
- Data stability:
  - A requester must hold req_data and req_last stable while req_valid=1 and req_ready=0.
  - The arbiter never drops or duplicates a beat.
- Latency:
  - First beat of a grant transfers no earlier than the cycle after arbitration.
  - Back-to-back beats within a grant transfer every cycle.
- wdata/wtag with winc=0: value don't-care, but must be driven (no X) after reset.
- Reset mid-burst: the grant is abandoned and the beat in that cycle is not written. Recovery is the requester's responsibility.
- MAX_BURST=1: every beat re-arbitrates, so throughput is 50% per requester.
- beat_cnt width is $clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1.

Test Plan:
- Only req 0 valid, 3-beat packet D0=0x11, D1=0x22, D2=0x33 (last on D2), wfull=0:
  - busy rises one cycle after valid.
  - winc high for 3 consecutive cycles with wdata 0x11/0x22/0x33, wtag=0.
  - Returns to IDLE; rr_ptr=1.
- Req 1 and req 3 both hold 1-beat packets continuously from reset:
  - Grant order 1,3,1,3…
  - winc pattern 1-0-1-0 (arbitration bubble between beats).
  - wtag alternates 1,3.
- Req 2 streams 10 beats with last only on beat 10, MAX_BURST=4, req 0 also valid:
  - Grant sequence is req2 4 beats, req0, req2 4 beats, req0, req2 2 beats.
  - No beat lost or reordered per source.
- wfull asserted for 5 cycles mid-packet of req 0:
  - winc=0 and req_ready=0 for those 5 cycles.
  - beat_cnt frozen.
  - Packet resumes with the next beat intact once wfull deasserts.
- wrst asserted during beat 2 of a 4-beat grant:
  - winc=0 in the reset cycle.
  - After release, state IDLE, rr_ptr=0.
  - Re-arbitration starts from req 0.
- rr_ptr wrap: grant to req NREQ-1=3 ends, then req 0 and req 2 are valid:
  - rr_ptr=0, so req 0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port scheduler: NREQ producers share one FIFO write port,
// one grant per packet or bounded burst, every beat tagged with its source.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        wtag,
  output logic                  busy
);
  localparam int             BW        = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0]  LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] TOP       = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_W    = (IDW+1)'(NREQ);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IDW-1:0]  cur, rr_ptr, pick;
  logic [BW-1:0]   beat_cnt;
  logic [IDW:0]    idx;
  logic            found, xfer, rel;

  // Cyclic scan starting at rr_ptr; the extra idx bit keeps rr_ptr+k from overflowing.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        pick  = idx[IDW-1:0];
      end
    end
  end

  assign xfer  = (state == GRANT) & req_valid[cur] & ~wfull & ~wrst;
  assign rel   = xfer & (req_last[cur] | (beat_cnt == LAST_BEAT));
  assign winc  = xfer;
  assign busy  = (state == GRANT) & ~wrst;
  assign wdata = req_data[cur*DSIZE +: DSIZE];
  assign wtag  = cur;

  for (genvar i = 0; i < NREQ; i++) begin : g_ready
    assign req_ready[i] = xfer & (cur == IDW'(i));
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state    <= IDLE;
      cur      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          cur      <= pick;
          beat_cnt <= '0;
          state    <= GRANT;
        end
        GRANT: if (rel) begin
          state    <= IDLE;
          rr_ptr   <= (cur == TOP) ? '0 : cur + 1'b1;
          beat_cnt <= '0;
        end else if (xfer) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule
